pi_spi_bridge: RTL and testbench
================================

// Module: pi_spi_bridge
// PURPOSE
//  SPI slave that lets the Raspberry Pi write and read the PET address space.
//  Decodes SPI frames into single-cycle strobes: pi_addr, pi_data, pi_write_strobe.
//  The keyboard matrix cache at $E800-$E809 and other Pi-visible state consume these strobes.
//  Also services Pi reads through pi_read_strobe / pi_data_in.
// PARAMETERS
//  SYNC_STAGES   2  flops in the SCLK/CS_n/MOSI synchronizers (>=2)
//  READ_LATENCY  2  clk cycles from pi_read_strobe to valid pi_data_in (>=1)
// PORTS
//  clk              in   1   system clock; must be >= 8x SCLK
//  reset_n          in   1   asynchronous, active-low reset
//  spi_sclk         in   1   SPI clock, mode 0 (CPOL=0, CPHA=0), MSB first
//  spi_cs_n         in   1   SPI chip select, active low, frames a transaction
//  spi_mosi         in   1   SPI data from Pi
//  spi_miso         out  1   SPI data to Pi
//  pi_addr          out  16  transaction address
//  pi_data          out  8   write data
//  pi_write_strobe  out  1   1-clk write pulse
//  pi_read_strobe   out  1   1-clk read request pulse
//  pi_data_in       in   8   read data, valid READ_LATENCY clks after pi_read_strobe
//  spi_error        out  1   1-clk pulse on unknown command byte
// BEHAVIOUR
//  Reset: all outputs 0; FSM = WAIT_CS_HIGH.
//   Clocking: one clock; reset is asynchronous and active-low.
//   A frame in progress when reset is released is ignored.
//   The next frame is accepted only after spi_cs_n is seen high and then falls.
//  Inputs: SCLK, CS_n and MOSI pass through SYNC_STAGES flops, then edge detection in clk domain.
//   MOSI is sampled on the synchronized SCLK rising edge.
//   A byte completes on the 8th rising edge after CS_n falls or after the previous byte.
//  Frames (byte 0 = command):
//   01 AH AL D            single write to {AH,AL}.
//   02 AH AL D0 D1 ..     sequential write; each Dn writes, then pi_addr+1.
//                         pi_addr wraps FFFF->0000.
//   03 AH AL xx           read; MISO returns mem[{AH,AL}] MSB-first during byte 3.
//                         Bytes after byte 3 are ignored; MISO=0.
//   other                 spi_error pulse; rest of frame ignored.
//  FSM states: WAIT_CS_HIGH, IDLE, CMD, ADDR_HI, ADDR_LO, DATA, READ_WAIT, READ_OUT, IGNORE.
//   IDLE -> CMD on CS_n fall.
//   CMD -> ADDR_HI on valid command; CMD -> IGNORE on unknown command.
//   ADDR_HI -> ADDR_LO.
//   ADDR_LO -> DATA for cmd 01/02; ADDR_LO -> READ_WAIT for cmd 03.
//   DATA -> IGNORE after the byte for cmd 01; DATA -> DATA for cmd 02.
//   READ_WAIT -> READ_OUT after READ_LATENCY.
//   READ_OUT -> IGNORE after 8 bits.
//  Write timing: pi_addr/pi_data are updated in the clk cycle after the data byte completes.
//   pi_write_strobe is high in that same cycle.
//   Both values are held until the next write/read; no strobe is issued for partial bytes.
//  Read timing: pi_addr is updated and pi_read_strobe pulses 1 clk after AL completes.
//   pi_data_in is captured READ_LATENCY clks later into the TX shift register.
//   MSB appears on MISO immediately; later bits shift on synchronized SCLK falling edges.
//   Host requirement: SCLK half-period > (SYNC_STAGES+READ_LATENCY+2) clks; otherwise MISO data undefined.
//  CS_n rise at any point: abort to IDLE, discard partial byte, no strobe.
//   A strobe already issued is not retracted.
//  spi_miso = 0 whenever not in READ_OUT.
//  Simultaneous CS_n rise and 8th SCLK edge (same synchronized cycle): the CS_n rise wins; byte discarded.
// TESTING
//  1 Frame 01 E8 03 7F -> exactly one pi_write_strobe.
//     pi_addr=E803, pi_data=7F at the strobe; no spi_error.
//  2 Frame 02 E8 00 then 10 bytes FE -> 10 strobes, pi_addr E800..E809, pi_data=FE each.
//  3 Frame 02 FF FF 11 22 -> strobes at FFFF (11), then 0000 (22).
//  4 Frame 03 E8 12 00, pi_data_in=A5 after READ_LATENCY -> one pi_read_strobe with pi_addr=E812.
//     MISO bits of byte 3 = A5.
//  5 Frame 01 E8 05 with CS_n raised after 4 bits of data -> no strobe; next frame 01 E8 05 3C writes 3C.
//  6 Frame starting 55 -> one spi_error pulse, no strobes; also reset_n low mid-frame -> outputs 0.
//     Remainder of that frame ignored.

Source files
------------

// File: rtl/pi_spi_bridge.sv
// rtl/pi_spi_bridge.sv - SPI mode-0 slave turning Pi frames into PET address-space write/read strobes
module pi_spi_bridge #(
  parameter int SYNC_STAGES  = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [15:0] pi_addr,
  output logic [7:0]  pi_data,
  output logic        pi_write_strobe,
  output logic        pi_read_strobe,
  input  logic [7:0]  pi_data_in,
  output logic        spi_error
);

  localparam int LAT_W = $clog2(READ_LATENCY + 1);

  typedef enum logic [3:0] {
    WAIT_CS_HIGH, IDLE, CMD, ADDR_HI, ADDR_LO, DATA, READ_WAIT, READ_OUT, IGNORE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             rx_q, rx_d;
  logic [7:0]             cmd_q, cmd_d;
  logic [7:0]             addr_hi_q, addr_hi_d;
  logic [15:0]            wr_addr_q, wr_addr_d;
  logic [LAT_W-1:0]       lat_cnt_q, lat_cnt_d;
  logic [7:0]             tx_q, tx_d;
  logic [15:0]            pi_addr_q, pi_addr_d;
  logic [7:0]             pi_data_q, pi_data_d;
  logic                   wr_strobe_q, wr_strobe_d;
  logic                   rd_strobe_q, rd_strobe_d;
  logic                   err_q, err_d;

  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise, sclk_fall, byte_done, in_frame;
  logic [7:0] rx_byte;

  always_comb begin
    state_d     = state_q;
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    cmd_d       = cmd_q;
    addr_hi_d   = addr_hi_q;
    wr_addr_d   = wr_addr_q;
    lat_cnt_d   = lat_cnt_q;
    tx_d        = tx_q;
    pi_addr_d   = pi_addr_q;
    pi_data_d   = pi_data_q;
    wr_strobe_d = 1'b0;
    rd_strobe_d = 1'b0;
    err_d       = 1'b0;

    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sclk_prev_d = sclk_s;
    sclk_rise   = sclk_s & ~sclk_prev_q;
    sclk_fall   = ~sclk_s & sclk_prev_q;
    rx_byte     = {rx_q[6:0], mosi_s};
    in_frame    = (state_q != WAIT_CS_HIGH) && (state_q != IDLE);
    // A CS_n rise in the same cycle as the 8th edge must discard the byte
    byte_done   = sclk_rise && (bit_cnt_q == 3'd7) && !cs_s;

    if (in_frame && sclk_rise) begin
      rx_d      = rx_byte;
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    case (state_q)
      WAIT_CS_HIGH: if (cs_s) state_d = IDLE;
      IDLE: begin
        if (!cs_s) begin
          state_d   = CMD;
          bit_cnt_d = 3'd0;
          rx_d      = 8'h00;
        end
      end
      CMD: begin
        if (byte_done) begin
          cmd_d = rx_byte;
          case (rx_byte)
            8'h01, 8'h02, 8'h03: state_d = ADDR_HI;
            default: begin
              err_d   = 1'b1;
              state_d = IGNORE;
            end
          endcase
        end
      end
      ADDR_HI: begin
        if (byte_done) begin
          addr_hi_d = rx_byte;
          state_d   = ADDR_LO;
        end
      end
      ADDR_LO: begin
        if (byte_done) begin
          if (cmd_q == 8'h03) begin
            pi_addr_d   = {addr_hi_q, rx_byte};
            rd_strobe_d = 1'b1;
            lat_cnt_d   = '0;
            state_d     = READ_WAIT;
          end else begin
            wr_addr_d = {addr_hi_q, rx_byte};
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (byte_done) begin
          pi_addr_d   = wr_addr_q;
          pi_data_d   = rx_byte;
          wr_strobe_d = 1'b1;
          wr_addr_d   = wr_addr_q + 16'd1;
          if (cmd_q == 8'h01) state_d = IGNORE;
        end
      end
      READ_WAIT: begin
        if (lat_cnt_q == LAT_W'(READ_LATENCY)) begin
          tx_d    = pi_data_in;
          state_d = READ_OUT;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      READ_OUT: begin
        // The fall that trails the AL byte arrives with bit_cnt 0 and must not shift
        if (sclk_fall && (bit_cnt_q != 3'd0)) tx_d = {tx_q[6:0], 1'b0};
        if (byte_done) state_d = IGNORE;
      end
      IGNORE: state_d = IGNORE;
      default: state_d = WAIT_CS_HIGH;
    endcase

    if (in_frame && cs_s) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= WAIT_CS_HIGH;
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      cmd_q       <= 8'h00;
      addr_hi_q   <= 8'h00;
      wr_addr_q   <= 16'h0000;
      lat_cnt_q   <= '0;
      tx_q        <= 8'h00;
      pi_addr_q   <= 16'h0000;
      pi_data_q   <= 8'h00;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      cmd_q       <= cmd_d;
      addr_hi_q   <= addr_hi_d;
      wr_addr_q   <= wr_addr_d;
      lat_cnt_q   <= lat_cnt_d;
      tx_q        <= tx_d;
      pi_addr_q   <= pi_addr_d;
      pi_data_q   <= pi_data_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
      err_q       <= err_d;
    end
  end

  assign spi_miso        = (state_q == READ_OUT) ? tx_q[7] : 1'b0;
  assign pi_addr         = pi_addr_q;
  assign pi_data         = pi_data_q;
  assign pi_write_strobe = wr_strobe_q;
  assign pi_read_strobe  = rd_strobe_q;
  assign spi_error       = err_q;

endmodule

// File: tb/tb_pi_spi_bridge.sv
// tb/tb_pi_spi_bridge.sv - scoreboard bench for pi_spi_bridge with directed SPI frames
module tb_pi_spi_bridge;

  localparam int RL   = 2;
  localparam int HALF = 10;
  localparam logic [1:0] K_WR = 2'd1, K_RD = 2'd2, K_ER = 2'd3;

  typedef struct {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [15:0] pi_addr;
  logic [7:0]  pi_data;
  logic        pi_write_strobe;
  logic        pi_read_strobe;
  logic [7:0]  pi_data_in = 8'h3C;
  logic        spi_error;

  int          n_vec = 0;
  int          n_err = 0;
  exp_t        sb[$];
  logic [7:0]  fb[$];
  logic [7:0]  rxq[$];
  logic [7:0]  rd_data = 8'h00;

  pi_spi_bridge #(.SYNC_STAGES(2), .READ_LATENCY(RL)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .spi_sclk        (spi_sclk),
    .spi_cs_n        (spi_cs_n),
    .spi_mosi        (spi_mosi),
    .spi_miso        (spi_miso),
    .pi_addr         (pi_addr),
    .pi_data         (pi_data),
    .pi_write_strobe (pi_write_strobe),
    .pi_read_strobe  (pi_read_strobe),
    .pi_data_in      (pi_data_in),
    .spi_error       (spi_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    e.kind = k; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = b[i];
      clks(HALF);
      r[i] = spi_miso;
      spi_sclk = 1'b1;
      clks(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic send_frame();
    logic [7:0] r;
    rxq.delete();
    spi_cs_n = 1'b0;
    clks(4);
    foreach (fb[i]) begin
      spi_bits(fb[i], 8, r);
      rxq.push_back(r);
    end
    clks(HALF);
    spi_cs_n = 1'b1;
    clks(10);
  endtask

  // Monitor: every strobe cycle must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    logic [1:0] seen;
    if (reset_n && (pi_write_strobe || pi_read_strobe || spi_error)) begin
      seen = pi_write_strobe ? K_WR : (pi_read_strobe ? K_RD : K_ER);
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_event: got kind %0d addr %0h data %0h, expected none", seen, pi_addr, pi_data);
      end else begin
        e = sb.pop_front();
        chk("event_kind", {30'd0, seen}, {30'd0, e.kind});
        if (e.kind != K_ER) chk("event_addr", {16'd0, pi_addr}, {16'd0, e.addr});
        if (e.kind == K_WR) chk("event_data", {24'd0, pi_data}, {24'd0, e.data});
      end
    end
  end

  // Memory model: read data valid exactly RL clocks after the strobe, garbage otherwise
  always begin
    @(negedge clk);
    if (pi_read_strobe) begin
      repeat (RL) @(posedge clk);
      #1 pi_data_in = rd_data;
      @(posedge clk);
      #1 pi_data_in = 8'h3C;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    clks(5);
    chk("reset_addr",  {16'd0, pi_addr}, 32'd0);
    chk("reset_data",  {24'd0, pi_data}, 32'd0);
    chk("reset_flags", {28'd0, pi_write_strobe, pi_read_strobe, spi_error, spi_miso}, 32'd0);
    reset_n = 1'b1;
    clks(10);

    push(K_WR, 16'hE803, 8'h7F);
    fb = '{8'h01, 8'hE8, 8'h03, 8'h7F};
    send_frame();
    chk("hold_addr", {16'd0, pi_addr}, 32'h0000E803);
    chk("hold_data", {24'd0, pi_data}, 32'h0000007F);
    chk("write_miso_zero", {24'd0, rxq[3]}, 32'd0);

    fb = '{8'h02, 8'hE8, 8'h00};
    for (int i = 0; i < 10; i++) begin
      push(K_WR, 16'hE800 + 16'(i), 8'hFE);
      fb.push_back(8'hFE);
    end
    send_frame();

    push(K_WR, 16'hFFFF, 8'h11);
    push(K_WR, 16'h0000, 8'h22);
    fb = '{8'h02, 8'hFF, 8'hFF, 8'h11, 8'h22};
    send_frame();

    rd_data = 8'hA5;
    push(K_RD, 16'hE812, 8'h00);
    fb = '{8'h03, 8'hE8, 8'h12, 8'h00, 8'hFF};
    send_frame();
    chk("read_miso", {24'd0, rxq[3]}, 32'h000000A5);
    chk("read_trailing_miso", {24'd0, rxq[4]}, 32'd0);

    spi_cs_n = 1'b0;
    clks(4);
    spi_bits(8'h01, 8, r);
    spi_bits(8'hE8, 8, r);
    spi_bits(8'h05, 8, r);
    spi_bits(8'h3C, 4, r);
    clks(HALF);
    spi_cs_n = 1'b1;
    clks(10);
    push(K_WR, 16'hE805, 8'h3C);
    fb = '{8'h01, 8'hE8, 8'h05, 8'h3C};
    send_frame();

    push(K_ER, 16'h0000, 8'h00);
    fb = '{8'h55, 8'h01, 8'hE8, 8'h00, 8'h12};
    send_frame();

    spi_cs_n = 1'b0;
    clks(4);
    spi_bits(8'h01, 8, r);
    spi_bits(8'hE8, 8, r);
    reset_n = 1'b0;
    #1;
    chk("midreset_addr",  {16'd0, pi_addr}, 32'd0);
    chk("midreset_data",  {24'd0, pi_data}, 32'd0);
    chk("midreset_flags", {28'd0, pi_write_strobe, pi_read_strobe, spi_error, spi_miso}, 32'd0);
    clks(3);
    reset_n = 1'b1;
    clks(2);
    spi_bits(8'h07, 8, r);
    spi_bits(8'h5A, 8, r);
    clks(HALF);
    spi_cs_n = 1'b1;
    clks(10);
    chk("post_reset_addr", {16'd0, pi_addr}, 32'd0);

    push(K_WR, 16'hE809, 8'hC3);
    fb = '{8'h01, 8'hE8, 8'h09, 8'hC3};
    send_frame();

    clks(20);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
